pcap_capture_mem_writer: RTL
============================

Name: pcap_capture_mem_writer

Overview:
- Write-side counterpart of the pcap replay engine: accepts AXI4-Stream packets (host/DMA-loaded pcap traffic) and serialises them into 144-bit memory words on a QDR write-request port.
- The replay reader later streams these words back out. It stops at the word count this block reports as mem_addr_high.
- Sits between the replay engine's s_axis input and the QDR controller write channel; all logic runs in the axi_aclk domain.

Parameters:
C_S_AXIS_DATA_WIDTH, 256, stream data width (fixed 256; tstrb = 32 bits)
C_S_AXIS_TUSER_WIDTH, 128, tuser width; tuser[15:0] = packet length in bytes
MEM_DATA_WIDTH, 144, memory word width (36 bits x burst 4)
QDR_ADDR_WIDTH, 19, word-address width
MEM_DEPTH, 2**19, number of writable words

Ports:
axi_aclk  in  1  clock
rst  in  1  synchronous, active-high reset
s_axis_tdata  in  256  packet data
s_axis_tstrb  in  32  byte strobes
s_axis_tuser  in  128  metadata (valid on first beat)
s_axis_tvalid  in  1  beat valid
s_axis_tready  out  1  beat accepted
s_axis_tlast  in  1  last beat of packet
mem_wr_req  out  1  write word valid
mem_wr_addr  out  19  word address
mem_wr_data  out  144  word data
mem_wr_ack  in  1  word accepted (req && ack = transfer)
capture_en  in  1  enable; rising edge restarts at address 0
mem_addr_high  out  19  words committed (end of last complete packet)
pkt_count  out  32  packets committed
drop_count  out  32  packets dropped
mem_full  out  1  sticky overflow flag

Behaviour:
- One clock; reset is synchronous and active-high, sampled on axi_aclk rising edge.
- Reset values: all outputs 0, FSM in IDLE, write pointer wp = 0.
- Packet layout, 2 words per unit:
  - Header word0 = {16'h0, tuser}; header word1 = 144'h0 (reserved).
  - Each beat: lo = {tstrb[15:0], tdata[127:0]}, hi = {tstrb[31:16], tdata[255:128]}.
  - A packet of N beats therefore uses 2*(N+1) words.
- FSM states: IDLE, HDR0, HDR1, DATA_LO, DATA_HI, DROP.
- IDLE:
  - If capture_en && tvalid: latch tuser and compute need = 2*(1+ceil(tuser[15:0]/32)); a length of 0 counts as 1 beat.
  - If wp+need > MEM_DEPTH: go to DROP. Otherwise go to HDR0, with start = wp.
  - tready = 0 in IDLE.
- Write states: mem_wr_req = 1 in HDR0, HDR1, DATA_LO and DATA_HI, with mem_wr_addr = wp.
  - Each ack increments wp and advances HDR0→HDR1→DATA_LO→DATA_HI.
  - A beat is held (tready = 0) through DATA_LO.
- DATA_HI: s_axis_tready = mem_wr_ack (combinational), so the beat is consumed exactly when its hi word is written.
  - On that ack without tlast: go to DATA_LO.
  - On that ack with tlast: mem_addr_high <= wp+1, pkt_count++, go to IDLE.
- If tvalid drops inside DATA_LO, mem_wr_req is deasserted and the FSM waits in DATA_LO.
- Overrun: when tlast arrives later than tuser length predicted and wp reaches MEM_DEPTH mid-packet:
  - Stop writing, set mem_full, go to DROP.
  - mem_addr_high keeps the previous packet end, so the partial packet is discarded.
  - wp rewinds to mem_addr_high.
- DROP:
  - tready = 1 and no writes; consume beats until tlast.
  - drop_count++ at tlast, mem_full <= 1, then go to IDLE.
- capture_en:
  - Sampled only in IDLE, so a deassert mid-packet finishes the current packet.
  - A rising edge detected in IDLE clears wp, mem_addr_high, pkt_count, drop_count and mem_full.
- Latency: the first header word is requested 1 cycle after tvalid is seen in IDLE. Throughput is 1 beat per 2 acked cycles.
- Counters wrap modulo 2^32.
- A reset mid-packet abandons the packet; upstream must flush.

Test Plan:
1. Reset, capture_en rise, one 3-beat packet (tuser[15:0] = 96) with mem_wr_ack held 1 -> 8 writes at addrs 0..7 in 8 consecutive cycles; word0[127:0] = tuser; mem_addr_high = 8, pkt_count = 1.
2. Four 3-beat packets back-to-back -> mem_addr_high = 32, pkt_count = 4; tready asserted exactly 12 times, only with mem_wr_ack.
3. mem_wr_ack toggled 1-0-1 randomly during a packet -> mem_wr_addr/data stable while req && !ack; no beat is lost or duplicated.
4. MEM_DEPTH = 16, wp = 12, packet with len 96 (need 8) -> no writes; all beats consumed; drop_count = 1, mem_full = 1, mem_addr_high = 12.
5. len field 32 but 4 beats sent, wp near MEM_DEPTH -> overrun mid-packet; mem_addr_high unchanged; next packet starts at old mem_addr_high.
6. rst asserted in DATA_HI -> next cycle all outputs 0, FSM IDLE; a new packet after rst is written from address 0.

Source files
------------

// File: rtl/pcap_capture_mem_writer_if.sv
// Bundles for the pcap capture writer: an AXI4-Stream input and a QDR write-request port.

interface pcap_axis_if #(
    parameter int DATA_WIDTH  = 256,
    parameter int TUSER_WIDTH = 128
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic [TUSER_WIDTH-1:0]  tuser;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

interface pcap_mem_wr_if #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 144
);
    logic                  req;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  ack;

    modport master (output req, addr, data, input ack);
    modport slave  (input req, addr, data, output ack);
endinterface

// File: rtl/pcap_capture_mem_writer.sv
// Serialises AXI4-Stream pcap packets into 144-bit QDR words (two header words, then two words
// per beat) and publishes mem_addr_high only once a packet has been written completely.

module pcap_capture_mem_writer #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int MEM_DATA_WIDTH       = 144,
    parameter int QDR_ADDR_WIDTH       = 19,
    parameter int MEM_DEPTH            = 2**19
) (
    input  logic                      axi_aclk,
    input  logic                      rst,
    pcap_axis_if.slave                s_axis,
    pcap_mem_wr_if.master             mem_wr,
    input  logic                      capture_en,
    output logic [QDR_ADDR_WIDTH-1:0] mem_addr_high,
    output logic [31:0]               pkt_count,
    output logic [31:0]               drop_count,
    output logic                      mem_full
);
    localparam int AW    = QDR_ADDR_WIDTH;
    localparam int HALF  = C_S_AXIS_DATA_WIDTH / 2;
    localparam int SHALF = C_S_AXIS_DATA_WIDTH / 16;
    localparam logic [31:0] DEPTH = 32'(MEM_DEPTH);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] HDR0    = 3'd1;
    localparam logic [2:0] HDR1    = 3'd2;
    localparam logic [2:0] DATA_LO = 3'd3;
    localparam logic [2:0] DATA_HI = 3'd4;
    localparam logic [2:0] DROP    = 3'd5;

    // Pointers carry one extra bit so a completely full memory (wp == MEM_DEPTH) is representable.
    logic [2:0]                      state;
    logic [AW:0]                     wp;
    logic [AW:0]                     addr_high;
    logic [C_S_AXIS_TUSER_WIDTH-1:0] tuser_q;
    logic                            cap_en_q;

    logic        cap_rise;
    logic [AW:0] base_wp;
    logic [16:0] beats_raw;
    logic [31:0] need;
    logic        fits;
    logic        at_end;
    logic        wr_fire;

    assign cap_rise  = capture_en && !cap_en_q;
    assign base_wp   = cap_rise ? '0 : wp;
    assign beats_raw = ({1'b0, s_axis.tuser[15:0]} + 17'd31) >> 5;

    always_comb begin
        need = 32'(beats_raw);
        if (beats_raw == '0) need = 32'd1;
        need = (need + 32'd1) << 1;
    end

    assign fits   = (32'(base_wp) + need) <= DEPTH;
    assign at_end = 32'(wp) >= DEPTH;

    // A data word is only requested while its beat is actually on the bus and memory remains.
    always_comb begin
        mem_wr.req = 1'b0;
        case (state)
            HDR0, HDR1: mem_wr.req = 1'b1;
            DATA_LO:    mem_wr.req = s_axis.tvalid && !at_end;
            DATA_HI:    mem_wr.req = !at_end;
            default:    mem_wr.req = 1'b0;
        endcase
    end

    assign wr_fire       = mem_wr.req && mem_wr.ack;
    assign s_axis.tready = (state == DATA_HI) ? wr_fire : (state == DROP);
    assign mem_wr.addr   = wp[AW-1:0];
    assign mem_addr_high = addr_high[AW-1:0];

    always_comb begin
        mem_wr.data = '0;
        case (state)
            HDR0:    mem_wr.data = MEM_DATA_WIDTH'(tuser_q);
            DATA_LO: mem_wr.data = MEM_DATA_WIDTH'({s_axis.tstrb[SHALF-1:0], s_axis.tdata[HALF-1:0]});
            DATA_HI: mem_wr.data = MEM_DATA_WIDTH'({s_axis.tstrb[2*SHALF-1:SHALF],
                                                    s_axis.tdata[2*HALF-1:HALF]});
            default: mem_wr.data = '0;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            state      <= IDLE;
            wp         <= '0;
            addr_high  <= '0;
            tuser_q    <= '0;
            cap_en_q   <= 1'b0;
            pkt_count  <= '0;
            drop_count <= '0;
            mem_full   <= 1'b0;
        end else begin
            cap_en_q <= capture_en;
            case (state)
                IDLE: begin
                    if (cap_rise) begin
                        wp         <= '0;
                        addr_high  <= '0;
                        pkt_count  <= '0;
                        drop_count <= '0;
                        mem_full   <= 1'b0;
                    end
                    if (capture_en && s_axis.tvalid) begin
                        tuser_q <= s_axis.tuser;
                        state   <= fits ? HDR0 : DROP;
                    end
                end
                HDR0: if (wr_fire) begin
                    wp    <= wp + 1'b1;
                    state <= HDR1;
                end
                HDR1: if (wr_fire) begin
                    wp    <= wp + 1'b1;
                    state <= DATA_LO;
                end
                // Running off the end mid-packet discards the partial packet by rewinding.
                DATA_LO, DATA_HI: begin
                    if (at_end) begin
                        mem_full <= 1'b1;
                        wp       <= addr_high;
                        state    <= DROP;
                    end else if (wr_fire) begin
                        wp <= wp + 1'b1;
                        if (state == DATA_LO) begin
                            state <= DATA_HI;
                        end else if (s_axis.tlast) begin
                            addr_high <= wp + 1'b1;
                            pkt_count <= pkt_count + 32'd1;
                            state     <= IDLE;
                        end else begin
                            state <= DATA_LO;
                        end
                    end
                end
                DROP: if (s_axis.tvalid && s_axis.tlast) begin
                    drop_count <= drop_count + 32'd1;
                    mem_full   <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
